// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: fixed-priority ALU results merged with
// FIFO-buffered memory results, r0 filtering and a starvation guard.
module writeback_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int CW = $clog2(FIFO_DEPTH) + 1,
  localparam int PW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [4:0]    alu_target,
  input  logic [31:0]   alu_data,
  output logic          alu_stall,
  input  logic          mem_valid,
  input  logic [4:0]    mem_target,
  input  logic [31:0]   mem_data,
  output logic          mem_ready,
  output logic          write_enable,
  output logic [4:0]    write_target,
  output logic [31:0]   write_data,
  output logic [CW-1:0] fifo_count,
  output logic          protocol_error
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_W = SW'(STARVE_LIMIT);
  localparam logic [CW-1:0] DEPTH_W = CW'(FIFO_DEPTH);

  logic [36:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [SW-1:0] starve_reg;
  logic          stall_reg;
  logic          we_reg;
  logic [4:0]    wt_reg;
  logic [31:0]   wd_reg;
  logic          perr_reg;

  logic          alu_grant;
  logic          fifo_nonempty;
  logic          pop;
  logic          push;
  logic [36:0]   head;

  assign fifo_nonempty = (count_reg != '0);
  assign alu_grant     = alu_valid && (alu_target != 5'd0) && !stall_reg;
  assign pop           = !alu_grant && fifo_nonempty;
  // Full blocks the push even when a pop frees a slot in the same cycle.
  assign mem_ready     = rst_n && (count_reg != DEPTH_W);
  assign push          = mem_valid && mem_ready && (mem_target != 5'd0);
  assign head          = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {mem_target, mem_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      starve_reg <= '0;
      stall_reg  <= 1'b0;
      we_reg     <= 1'b0;
      wt_reg     <= '0;
      wd_reg     <= '0;
      perr_reg   <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);

      if (alu_grant) begin
        we_reg <= 1'b1;
        wt_reg <= alu_target;
        wd_reg <= alu_data;
      end else if (pop) begin
        we_reg <= 1'b1;
        wt_reg <= head[36:32];
        wd_reg <= head[31:0];
      end else begin
        we_reg <= 1'b0;
      end

      // Stall the ALU for one cycle once it has won STARVE_LIMIT times over a waiting FIFO.
      stall_reg <= 1'b0;
      if (pop || !fifo_nonempty) begin
        starve_reg <= '0;
      end else if (alu_grant) begin
        starve_reg <= starve_reg + SW'(1);
        if (starve_reg + SW'(1) == LIMIT_W) stall_reg <= 1'b1;
      end

      if (alu_valid && stall_reg) perr_reg <= 1'b1;
    end
  end

  assign alu_stall      = stall_reg;
  assign write_enable   = we_reg;
  assign write_target   = wt_reg;
  assign write_data     = wd_reg;
  assign fifo_count     = count_reg;
  assign protocol_error = perr_reg;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed-vector bench for writeback_arbiter (FIFO_DEPTH=4, STARVE_LIMIT=8).
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_target;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mem_valid;
  logic [4:0]  mem_target;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        write_enable;
  logic [4:0]  write_target;
  logic [31:0] write_data;
  logic [2:0]  fifo_count;
  logic        protocol_error;

  int tests_run = 0;
  int tests_failed = 0;

  writeback_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_target(alu_target), .alu_data(alu_data),
    .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_target(mem_target), .mem_data(mem_data),
    .mem_ready(mem_ready),
    .write_enable(write_enable), .write_target(write_target), .write_data(write_data),
    .fifo_count(fifo_count), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_target = '0; alu_data = '0;
    mem_valid = 1'b0; mem_target = '0; mem_data = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #3;
    check("rst_we", write_enable, 0);
    check("rst_cnt", fifo_count, 0);
    check("rst_stall", alu_stall, 0);
    check("rst_perr", protocol_error, 0);
    #9 rst_n = 1'b1;
    #1 check("rst_ready", mem_ready, 1);

    // ALU only
    alu_valid = 1; alu_target = 3; alu_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    check("alu_we", write_enable, 1);
    check("alu_wt", write_target, 3);
    check("alu_wd", write_data, 32'hDEADBEEF);
    tick();
    check("alu_we_off", write_enable, 0);
    check("alu_wt_hold", write_target, 3);

    // r0 filter on both sources
    alu_valid = 1; alu_target = 0; alu_data = 32'h1111;
    mem_valid = 1; mem_target = 0; mem_data = 32'h2222;
    check("r0_ready", mem_ready, 1);
    tick();
    idle_inputs();
    check("r0_we", write_enable, 0);
    check("r0_cnt", fifo_count, 0);
    tick();
    check("r0_we2", write_enable, 0);

    // Fill FIFO while ALU is busy every cycle
    alu_valid = 1; alu_target = 5;
    for (int k = 0; k < 4; k++) begin
      alu_data = 32'(k); mem_valid = 1; mem_target = 5'(10 + k); mem_data = 32'h100 + 32'(k);
      tick();
      check($sformatf("fill_cnt%0d", k), fifo_count, 64'(k + 1));
      check($sformatf("fill_wt%0d", k), write_target, 5);
    end
    check("full_ready", mem_ready, 0);
    mem_target = 14; mem_data = 32'h104;
    tick();
    check("full_hold_cnt", fifo_count, 4);
    check("full_hold_ready", mem_ready, 0);
    alu_valid = 0;
    tick();
    check("drain_wt0", write_target, 10);
    check("drain_wd0", write_data, 32'h100);
    check("drain_cnt0", fifo_count, 3);
    tick();
    mem_valid = 0;
    check("drain_wt1", write_target, 11);
    check("drain_cnt1", fifo_count, 3);
    for (int j = 2; j < 5; j++) begin
      tick();
      check($sformatf("drain_we%0d", j), write_enable, 1);
      check($sformatf("drain_wt%0d", j), write_target, 64'(10 + j));
      check($sformatf("drain_wd%0d", j), write_data, 64'(32'h100 + j));
      check($sformatf("drain_cnt%0d", j), fifo_count, 64'(4 - j));
    end
    tick();
    check("drain_idle", write_enable, 0);

    // Starvation: one entry waits behind eight ALU grants
    alu_valid = 1; alu_target = 6; alu_data = 32'h66;
    mem_valid = 1; mem_target = 20; mem_data = 32'hAAAA;
    tick();
    mem_valid = 0;
    check("starve_cnt", fifo_count, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("starve_stall%0d", i), alu_stall, (i == 8) ? 1 : 0);
    end
    check("starve_last_alu", write_target, 6);
    alu_valid = 0;
    tick();
    check("starve_pop_wt", write_target, 20);
    check("starve_pop_wd", write_data, 32'hAAAA);
    check("starve_unstall", alu_stall, 0);
    check("starve_cnt0", fifo_count, 0);
    check("starve_perr", protocol_error, 0);

    // Protocol violation: ALU ignores the stall
    alu_valid = 1; alu_target = 6; alu_data = 32'h66;
    mem_valid = 1; mem_target = 21; mem_data = 32'hBBBB;
    tick();
    mem_valid = 0;
    for (int i = 1; i <= 8; i++) tick();
    check("viol_stall", alu_stall, 1);
    alu_target = 7; alu_data = 32'h77;
    tick();
    alu_valid = 0;
    check("viol_wt", write_target, 21);
    check("viol_wd", write_data, 32'hBBBB);
    check("viol_perr", protocol_error, 1);
    tick();
    check("viol_dropped", write_enable, 0);
    check("viol_sticky", protocol_error, 1);

    // Reset mid-operation with three entries buffered
    alu_valid = 1; alu_target = 8;
    for (int k = 0; k < 3; k++) begin
      mem_valid = 1; mem_target = 5'(24 + k); mem_data = 32'(k);
      tick();
    end
    idle_inputs();
    check("pre_rst_cnt", fifo_count, 3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_we", write_enable, 0);
    check("mid_rst_wt", write_target, 0);
    check("mid_rst_wd", write_data, 0);
    check("mid_rst_cnt", fifo_count, 0);
    check("mid_rst_perr", protocol_error, 0);
    #10 rst_n = 1'b1;
    tick();
    check("post_rst_we", write_enable, 0);
    tick();
    check("post_rst_we2", write_enable, 0);
    check("post_rst_cnt", fifo_count, 0);
    check("post_rst_ready", mem_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
